bank_scan_sequencer: RTL



---
 rtl/day3_pkg.sv | 21 ++
 rtl/credit_counter.sv | 41 ++++
 rtl/bank_scan_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/day3_pkg.sv
// Shared types and default sizes for the day-3 bank scan: scan state encoding,
// datapath widths and the reference score for the real puzzle input.
package day3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  localparam int NUM_LINES_DEF    = 200;
  localparam int ADDR_W_DEF       = 8;
  localparam int VAL_W_DEF        = 8;
  localparam int SCORE_W_DEF      = 32;
  localparam int MAX_INFLIGHT_DEF = 4;

  // Score of one full scan over the real battery-bank ROM.
  localparam int EXPECTED_SCORE   = 16764;

endpackage

// File: rtl/credit_counter.sv
// In-flight line counter for the bank scan: counts issues up and retires down,
// flags the credit limit and retires that arrive with nothing outstanding.
module credit_counter
  import day3_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic at_limit,
  output logic empty,
  output logic underflow
);

  logic [CNT_W-1:0] count;
  logic             take;

  // A retire against an empty counter is reported, never applied.
  assign take = dec && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !take) begin
      count <= count + 1'b1;
    end else if (!inc && take) begin
      count <= count - 1'b1;
    end
  end

  assign at_limit  = (count >= CNT_W'(MAX_INFLIGHT));
  assign empty     = (count == '0);
  assign underflow = dec && empty;

endmodule

// File: rtl/bank_scan_sequencer.sv
// Drives one full ROM scan through the joltage pipeline under a credit limit and
// accumulates the score. Define SCAN_CYCLE_COUNT_EN to add the cycle_count port.
//
// state | meaning
// IDLE  | after reset, waiting for start
// ISSUE | issuing line addresses while credits remain
// DRAIN | all lines issued, waiting for outstanding results
// DONE  | scan complete, score held until next start
module bank_scan_sequencer
  import day3_pkg::*;
#(
  parameter int NUM_LINES    = NUM_LINES_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int VAL_W        = VAL_W_DEF,
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               pipe_out_valid,
  input  logic [VAL_W-1:0]   pipe_out_value,
  output logic [SCORE_W-1:0] score,
`ifdef SCAN_CYCLE_COUNT_EN
  output logic [31:0]        cycle_count,
`endif
  output logic               overflow_err
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LINES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] issue_cnt;
  logic              accept;
  logic              in_scan;
  logic              issue;
  logic              last_issue;
  logic              retire;
  logic              at_limit;
  logic              empty;
  logic              underflow;

  assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign in_scan    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign issue      = (state == ST_ISSUE) && !at_limit;
  assign last_issue = issue && (issue_cnt == LAST_ADDR);
  // Results outside a scan never touch the credit count or the score.
  assign retire     = pipe_out_valid && in_scan;

  assign busy = in_scan;
  assign done = (state == ST_DONE);

  credit_counter #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CNT_W       (4)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .inc      (issue),
    .dec      (retire),
    .at_limit (at_limit),
    .empty    (empty),
    .underflow(underflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start)      state <= ST_ISSUE;
        ST_ISSUE:         if (last_issue) state <= ST_DRAIN;
        ST_DRAIN:         if (empty)      state <= ST_DONE;
        default:                          state <= ST_IDLE;
      endcase
    end
  end

  // issue_cnt parks on the last line so rom_addr can never pass NUM_LINES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      issue_cnt <= '0;
    end else begin
      rom_en <= issue;
      if (issue) rom_addr <= issue_cnt;
      if (accept) begin
        issue_cnt <= '0;
      end else if (issue && !last_issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score        <= '0;
      overflow_err <= 1'b0;
    end else if (accept) begin
      score        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (retire) score <= score + SCORE_W'(pipe_out_value);
      if (underflow || (pipe_out_valid && (state == ST_DONE))) overflow_err <= 1'b1;
    end
  end

`ifdef SCAN_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (accept) begin
      cycle_count <= '0;
    end else if (in_scan) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule
